// File: rtl/dcache_axi_line_writer_pkg.sv
// Shared AXI constants, line geometry and FSM encoding for the DCache AXI line writer.
package dcache_axi_line_writer_pkg;

  localparam int unsigned LINE_W = 256;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned BEATS  = LINE_W / DATA_W;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_8B    = 3'b011;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StResp,
    StDone
  } state_e;

endpackage

// File: rtl/dcache_line_serializer.sv
// Holds one captured cache line and presents it one AXI data beat at a time.
module dcache_line_serializer #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [LINE_W-1:0] line_i,
  input  logic              advance_i,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o
);

  localparam int unsigned BEATS = LINE_W / DATA_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [BEATS-1:0][DATA_W-1:0] line_q;
  logic [CNT_W-1:0]             cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      line_q <= line_i;
      cnt_q  <= '0;
    end else if (advance_i) begin
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  // Beat 0 is the low word of the line.
  assign data_o = line_q[cnt_q];
  assign last_o = (cnt_q == CNT_W'(BEATS - 1));

endmodule

// File: rtl/dcache_axi_line_writer.sv
// Drains the write-buffer head line as a single 4-beat AXI4 INCR burst and pulses completion
// when the B response returns. One burst outstanding at a time, AW always before W.
module dcache_axi_line_writer
  import dcache_axi_line_writer_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned DATA_W = 64,
  parameter logic [3:0]  AXI_ID = 4'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              buf_wen_i,
  input  logic [LINE_W-1:0] buf_wdata_i,
  input  logic [ADDR_W-1:0] buf_awaddr_i,
  output logic              buf_bvalid_o,
  output logic              wr_err_o,
  output logic              axi_awvalid_o,
  input  logic              axi_awready_i,
  output logic [ADDR_W-1:0] axi_awaddr_o,
  output logic [3:0]        axi_awid_o,
  output logic [7:0]        axi_awlen_o,
  output logic [2:0]        axi_awsize_o,
  output logic [1:0]        axi_awburst_o,
  output logic              axi_wvalid_o,
  input  logic              axi_wready_i,
  output logic [DATA_W-1:0] axi_wdata_o,
  output logic [7:0]        axi_wstrb_o,
  output logic              axi_wlast_o,
  input  logic              axi_bvalid_i,
  output logic              axi_bready_o,
  input  logic [1:0]        axi_bresp_i,
  input  logic [3:0]        axi_bid_i
);

  localparam int unsigned NBEATS = LINE_W / DATA_W;
  localparam int unsigned OFF_W  = $clog2(LINE_W / 8);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic              load, advance, last;
  logic              unused_addr_bits;

  // Line-offset bits are discarded: the burst always starts on the line boundary.
  assign unused_addr_bits = ^buf_awaddr_i[OFF_W-1:0];

  dcache_line_serializer #(
    .LINE_W (LINE_W),
    .DATA_W (DATA_W)
  ) u_serializer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .line_i    (buf_wdata_i),
    .advance_i (advance),
    .data_o    (axi_wdata_o),
    .last_o    (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    err_d   = err_q;
    load    = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (buf_wen_i) begin
          load    = 1'b1;
          addr_d  = {buf_awaddr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (axi_awready_i) state_d = StData;
      end
      StData: begin
        if (axi_wready_i) begin
          advance = 1'b1;
          if (last) state_d = StResp;
        end
      end
      StResp: begin
        if (axi_bvalid_i) begin
          err_d   = (axi_bresp_i != RESP_OKAY) || (axi_bid_i != AXI_ID);
          state_d = StDone;
        end
      end
      // Completion cycle: the request input is ignored so the buffer retires its head first.
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign axi_awvalid_o = (state_q == StAddr);
  assign axi_awaddr_o  = addr_q;
  assign axi_awid_o    = AXI_ID;
  assign axi_awlen_o   = 8'(NBEATS - 1);
  assign axi_awsize_o  = SIZE_8B;
  assign axi_awburst_o = BURST_INCR;
  assign axi_wvalid_o  = (state_q == StData);
  assign axi_wstrb_o   = 8'hFF;
  assign axi_wlast_o   = (state_q == StData) && last;
  assign axi_bready_o  = (state_q == StResp);
  assign buf_bvalid_o  = (state_q == StDone);
  assign wr_err_o      = (state_q == StDone) && err_q;

endmodule
